// File: rtl/pmem_responder.sv
// Physical-memory responder for the 128-bit cache line interface.
// Accepts one read or write at a time, waits a programmable number of
// cycles, then pulses pmem_resp for one cycle. Line storage is not reset.
module pmem_responder #(
    parameter int unsigned LATENCY    = 8,
    parameter int unsigned LINE_IDX_W = 12
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [127:0] pmem_rdata,
    output logic         proto_err
);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    // Counter load value at acceptance; the last BUSY cycle is the one with cnt == 1.
    localparam logic [7:0] CntInit = 8'(LATENCY - 1);
    localparam int unsigned NumLines = 2 ** LINE_IDX_W;

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [LINE_IDX_W-1:0] idx_q, idx_d;
    logic [127:0]          wdata_q, wdata_d;
    logic                  op_write_q, op_write_d;
    logic                  proto_err_q, proto_err_d;
    logic [127:0]          rdata_q;
    logic                  load_rdata;
    logic                  commit;
    logic                  req_dropped;

    logic [127:0] mem [NumLines];

    // Only the line-index bits select storage; the rest of the address is don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^pmem_address;

    // The request line that matters is the one belonging to the accepted op.
    assign req_dropped = op_write_q ? !pmem_write : !pmem_read;

    // Next-state, operand latching and protocol checking.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        op_write_d  = op_write_q;
        proto_err_d = proto_err_q;
        load_rdata  = 1'b0;
        commit      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pmem_read || pmem_write) begin
                    idx_d      = pmem_address[LINE_IDX_W+3:4];
                    wdata_d    = pmem_wdata;
                    // Write wins when both requests are raised together.
                    op_write_d = pmem_write;
                    cnt_d      = CntInit;
                    if (pmem_read && pmem_write) begin
                        proto_err_d = 1'b1;
                    end
                    if (LATENCY == 1) begin
                        state_d    = StResp;
                        load_rdata = !pmem_write;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (req_dropped) begin
                    // Initiator gave up: abandon without response or storage update.
                    state_d     = StIdle;
                    cnt_d       = 8'd0;
                    proto_err_d = 1'b1;
                end else if (cnt_q == 8'd1) begin
                    state_d    = StResp;
                    cnt_d      = 8'd0;
                    load_rdata = !op_write_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
                commit  = op_write_q;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state and read-data register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            idx_q       <= '0;
            wdata_q     <= '0;
            op_write_q  <= 1'b0;
            proto_err_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            op_write_q  <= op_write_d;
            proto_err_q <= proto_err_d;
            // idx_d covers both the LATENCY==1 path (fresh address) and the BUSY path.
            if (load_rdata) begin
                rdata_q <= mem[idx_d];
            end
        end
    end

    // Line storage: write commits on the edge leaving RESP. A reset forces IDLE,
    // which kills commit before any edge can use it.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign pmem_resp  = (state_q == StResp);
    assign pmem_rdata = rdata_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: a LATENCY=8 instance (index 0) and a LATENCY=1
// instance (index 1), each tracked by a transaction-level model.
module tb_pmem_responder;

    localparam int unsigned LAT0 = 8;
    localparam int unsigned LAT1 = 1;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         rd   [2];
    logic         wr   [2];
    logic [15:0]  ad   [2];
    logic [127:0] wd   [2];
    logic         resp [2];
    logic [127:0] rdat [2];
    logic         perr [2];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pmem_responder #(.LATENCY(LAT0), .LINE_IDX_W(12)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .pmem_read(rd[0]), .pmem_write(wr[0]),
        .pmem_address(ad[0]), .pmem_wdata(wd[0]), .pmem_resp(resp[0]),
        .pmem_rdata(rdat[0]), .proto_err(perr[0])
    );

    pmem_responder #(.LATENCY(LAT1), .LINE_IDX_W(12)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .pmem_read(rd[1]), .pmem_write(wr[1]),
        .pmem_address(ad[1]), .pmem_wdata(wd[1]), .pmem_resp(resp[1]),
        .pmem_rdata(rdat[1]), .proto_err(perr[1])
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A transaction accepted at edge k completes at edge k+LATENCY; resp is
    // visible in the cycle just before that edge. Writes land at completion.
    bit           m_busy   [2];
    bit           m_w      [2];
    bit           m_perr   [2];
    bit           m_rknown [2];
    int           m_redge  [2];
    int           m_idx    [2];
    logic [127:0] m_wd     [2];
    logic [127:0] m_rdata  [2];
    logic [127:0] mm [int];

    function automatic int lat(input int i);
        return (i == 0) ? int'(LAT0) : int'(LAT1);
    endfunction

    function automatic int key(input int i, input int idx);
        return i * 65536 + idx;
    endfunction

    task automatic load_rd(input int i);
        if (mm.exists(key(i, m_idx[i]))) begin
            m_rdata[i]  = mm[key(i, m_idx[i])];
            m_rknown[i] = 1'b1;
        end else begin
            m_rknown[i] = 1'b0;
        end
    endtask

    initial begin
        int k;
        forever begin
            @(posedge clk or negedge reset_n);
            k = cyc + 1;
            for (int i = 0; i < 2; i++) begin
                if (!reset_n) begin
                    m_busy[i]   = 1'b0;
                    m_perr[i]   = 1'b0;
                    m_rdata[i]  = '0;
                    m_rknown[i] = 1'b1;
                end else if (m_busy[i]) begin
                    if (k == m_redge[i]) begin
                        m_busy[i] = 1'b0;
                        if (m_w[i]) mm[key(i, m_idx[i])] = m_wd[i];
                    end else if (m_w[i] ? !wr[i] : !rd[i]) begin
                        m_busy[i] = 1'b0;
                        m_perr[i] = 1'b1;
                    end else if (k + 1 == m_redge[i] && !m_w[i]) begin
                        load_rd(i);
                    end
                end else if (rd[i] || wr[i]) begin
                    m_busy[i]  = 1'b1;
                    m_w[i]     = wr[i];
                    m_idx[i]   = int'(ad[i][15:4]);
                    m_wd[i]    = wd[i];
                    m_redge[i] = k + lat(i);
                    if (rd[i] && wr[i]) m_perr[i] = 1'b1;
                    if (k + 1 == m_redge[i] && !m_w[i]) load_rd(i);
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        bit exp_resp;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                exp_resp = m_busy[i] && (cyc + 1 == m_redge[i]);
                chk($sformatf("resp%0d", i), 128'(resp[i]), 128'(exp_resp));
                chk($sformatf("proto_err%0d", i), 128'(perr[i]), 128'(m_perr[i]));
                if (m_rknown[i]) chk($sformatf("rdata%0d", i), rdat[i], m_rdata[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Drive a request and hold it until resp; returns with the request still
    // asserted just after the edge that leaves RESP.
    task automatic txn(input int i, input bit r, input bit w, input logic [15:0] a,
                       input logic [127:0] d, input bit scramble,
                       output int rc, output int dc);
        rd[i] = r;
        wr[i] = w;
        ad[i] = a;
        wd[i] = d;
        dc = cyc;
        rc = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (scramble && n == 1) begin
                ad[i] = 16'h0000;
                wd[i] = {$urandom, $urandom, $urandom, $urandom};
            end
            if (resp[i]) begin
                rc = cyc;
                break;
            end
        end
        if (rc < 0) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout: got no resp on dut%0d expected resp within 300 cycles", i);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int i, input int n);
        rd[i] = 1'b0;
        wr[i] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc, dc, prev, cnt, line;
        bit w;
        bit seen [8];
        logic [127:0] d;
        localparam logic [127:0] LineA = 128'hDEADBEEF_00000001_CAFEF00D_12345678;
        localparam logic [127:0] LineB = 128'h11112222_33334444_55556666_77778888;
        localparam logic [127:0] Line5A = {16{8'h5A}};

        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; wd[i] = '0;
        end
        for (int j = 0; j < 8; j++) seen[j] = 1'b0;

        // Reset with a read already pending.
        reset_n = 1'b0;
        rd[0] = 1'b1;
        ad[0] = 16'h0100;
        repeat (3) @(posedge clk);
        #1;
        chk("resp_in_reset", 128'(resp[0]), 128'd0);
        chk("rdata_in_reset", rdat[0], 128'd0);
        reset_n = 1'b1;
        txn(0, 1'b1, 1'b0, 16'h0100, '0, 1'b0, rc, dc);
        chk("first_latency", 128'(rc - dc), 128'd8);

        // Write then read of the same line, back to back.
        txn(0, 1'b0, 1'b1, 16'h1230, LineA, 1'b0, rc, dc);
        prev = rc;
        chk("write_latency", 128'(rc - dc), 128'd8);
        txn(0, 1'b1, 1'b0, 16'h123C, '0, 1'b0, rc, dc);
        chk("wr_rd_data", rdat[0], LineA);
        chk("b2b_spacing", 128'(rc - prev), 128'd9);
        chk("resp_width", 128'(resp[0]), 128'd0);
        idle(0, 2);

        // Operands latched at acceptance.
        txn(0, 1'b1, 1'b0, 16'h1230, '0, 1'b1, rc, dc);
        chk("latched_rdata", rdat[0], LineA);
        idle(0, 2);

        // Abort: drop read 3 cycles after acceptance.
        rd[0] = 1'b1;
        ad[0] = 16'h0000;
        repeat (4) @(posedge clk);
        #1;
        rd[0] = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (resp[0]) cnt++;
        end
        chk("abort_no_resp", 128'(cnt), 128'd0);
        chk("abort_perr", 128'(perr[0]), 128'd1);
        #1;
        txn(0, 1'b0, 1'b1, 16'h0008, LineB, 1'b0, rc, dc);
        chk("post_abort_latency", 128'(rc - dc), 128'd8);
        idle(0, 1);
        txn(0, 1'b1, 1'b0, 16'h0000, '0, 1'b0, rc, dc);
        chk("post_abort_read", rdat[0], LineB);
        idle(0, 1);

        // Reset clears the sticky flag; then read/write conflict.
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("perr_cleared", 128'(perr[0]), 128'd0);
        reset_n = 1'b1;
        txn(0, 1'b1, 1'b1, 16'h0040, Line5A, 1'b0, rc, dc);
        chk("conflict_perr", 128'(perr[0]), 128'd1);
        idle(0, 1);
        txn(0, 1'b1, 1'b0, 16'h0040, '0, 1'b0, rc, dc);
        chk("conflict_read", rdat[0], Line5A);
        idle(0, 1);

        // Reset mid-write: storage must keep the earlier line.
        txn(0, 1'b0, 1'b1, 16'h0080, LineA, 1'b0, rc, dc);
        idle(0, 1);
        wr[0] = 1'b1;
        ad[0] = 16'h0080;
        wd[0] = LineB;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("resp_mid_reset", 128'(resp[0]), 128'd0);
        @(posedge clk);
        #1;
        wr[0] = 1'b0;
        reset_n = 1'b1;
        idle(0, 1);
        txn(0, 1'b1, 1'b0, 16'h0080, '0, 1'b0, rc, dc);
        chk("mid_reset_no_write", rdat[0], LineA);
        idle(0, 1);

        // LATENCY=1 instance: 100 back-to-back random transactions.
        txn(1, 1'b0, 1'b1, 16'h0000, LineA, 1'b0, rc, dc);
        chk("l1_latency", 128'(rc - dc), 128'd1);
        seen[0] = 1'b1;
        prev = rc;
        for (int n = 0; n < 100; n++) begin
            line = int'($urandom_range(0, 7));
            w = ($urandom_range(0, 1) == 1) || !seen[line];
            d = {$urandom, $urandom, $urandom, $urandom};
            txn(1, !w, w, {4'h0, 8'(line), 4'($urandom_range(0, 15))}, d, 1'b0, rc, dc);
            if (w) seen[line] = 1'b1;
            chk("l1_spacing", 128'(rc - prev), 128'd2);
            prev = rc;
        end
        idle(1, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
- Physical-memory side of the 128-bit line interface that the cache drives. It is the responder for `pmem_read` / `pmem_write` / `pmem_address` / `pmem_wdata`.
- Holds line storage and returns `pmem_resp` after a programmable access latency. It replaces the behavioural memory model in the mp2 top-level bench and is synthesizable for the FPGA build.
- Serves one transaction at a time. The address and write data are latched when the request is accepted.

Parameters:
- LATENCY, 8: cycles from request acceptance to the `pmem_resp` cycle. Legal range is 1..255.
- LINE_IDX_W, 12: line-index width. Storage is 2**LINE_IDX_W lines of 128 bits. The index is `pmem_address[LINE_IDX_W+3:4]`.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- pmem_read  in  1  line read request. Held by the initiator until `pmem_resp`.
- pmem_write  in  1  line write request. Held by the initiator until `pmem_resp`.
- pmem_address  in  16  byte address. Bits [3:0] are ignored (line aligned).
- pmem_wdata  in  128  write line data.
- pmem_resp  out  1  one-cycle completion pulse.
- pmem_rdata  out  128  read line data. Valid in the `pmem_resp` cycle of a read.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async assert, sync release):
  - State returns to IDLE.
  - Outputs: `pmem_resp`=0, `pmem_rdata`=0, `proto_err`=0.
  - Latency counter is cleared.
  - Storage contents are NOT reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If `pmem_read` or `pmem_write` is 1 at the edge, the request is accepted.
  - Latch the line index, `pmem_wdata` and the op type. Load `cnt` = LATENCY-1.
  - If LATENCY==1, go to RESP; otherwise go to BUSY.
- Read and write both 1 at acceptance:
  - Write wins.
  - Set `proto_err`.
- BUSY:
  - `cnt` decrements each cycle. When `cnt` reaches 1, go to RESP.
  - Acceptance at edge T means `pmem_resp` is high during cycle T+LATENCY.
  - If the accepted request line (`pmem_read` for reads, `pmem_write` for writes) drops during BUSY, the transaction aborts:
    - Go to IDLE with no `pmem_resp` and no storage write.
    - Set `proto_err`.
- RESP:
  - `pmem_resp`=1 for exactly one cycle.
  - Read: `pmem_rdata` = storage[latched index], registered on entry to RESP.
  - Write: storage[latched index] <= latched wdata, committed on the edge leaving RESP.
  - Next state is always IDLE.
- `pmem_rdata` holds its last value outside RESP cycles and is not cleared after a response.
- Changes to `pmem_address` or `pmem_wdata` after acceptance are ignored.
- Back-to-back transactions:
  - A request still asserted in the IDLE cycle after RESP is accepted as a new transaction. Example: a writeback followed by a fill to a different address.
  - Minimum spacing between consecutive `pmem_resp` pulses is LATENCY+1 cycles.
- A write immediately followed by a read of the same line returns the new data. The commit happens before the next acceptance edge.
- Reset asserted mid-transaction:
  - The transaction is dropped and no storage write occurs.
  - `pmem_resp` goes low asynchronously.
- `proto_err` clears only on reset.

Test Plan:
- Reset and idle: assert reset_n=0 with `pmem_read`=1, then release. Required: `pmem_resp`=0 throughout reset; after release, first acceptance at the next edge and `pmem_resp` exactly LATENCY=8 cycles later.
- Write then read:
  - Write line addr 16'h1230 with data 128'hDEADBEEF_00000001_CAFEF00D_12345678, hold until resp.
  - Then read addr 16'h123C.
  - Required: the read returns that same line in its resp cycle; the resp pulses are 1 cycle wide; read acceptance is the edge after the write's RESP.
- Latched operands: after read acceptance at 16'h1230, change `pmem_address` to 16'h0000 and `pmem_wdata` to random. Required: `pmem_rdata` equals the line at 16'h1230.
- Abort: drop `pmem_read` 3 cycles after acceptance. Required: no `pmem_resp`, state IDLE, `proto_err`=1; a subsequent write/read of line 0 works normally.
- Conflict: assert read and write together at 16'h0040 with wdata=128'h5A..5A. Required: the write is performed, a later read returns 128'h5A..5A, `proto_err`=1.
- LATENCY=1 build: resp in the cycle after acceptance; 100 random back-to-back read/write transactions match a scoreboard; resp spacing is 2 cycles.
